// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: merges write-back stage writes with buffered
// long-latency results, with a starvation guard that forces the buffered head through.
module rf_wport_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ws_we,
  input  logic [4:0]  ws_waddr,
  input  logic [31:0] ws_wdata,
  output logic        ws_ready,
  input  logic        lt_valid,
  output logic        lt_ready,
  input  logic [4:0]  lt_waddr,
  input  logic [31:0] lt_wdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] pend_mask
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_WS,
    GNT_LT
  } gnt_e;

  logic [1:0]  occ_q, occ_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic [4:0]  addr_q [2];
  logic [4:0]  addr_d [2];
  logic [31:0] data_q [2];
  logic [31:0] data_d [2];

  gnt_e        gnt;
  logic        fifo_nempty;
  logic        fifo_full;
  logic        starve;
  logic        push;
  logic        pop;
  logic [4:0]  head_addr;
  logic [31:0] head_data;
  logic [1:0]  ent_vld;

  always_comb begin
    fifo_nempty = (occ_q != 2'd0);
    fifo_full   = (occ_q == 2'd2);
    starve      = fifo_nempty && (starve_cnt_q == STARVE_LIM);
    head_addr   = addr_q[rd_ptr_q];
    head_data   = data_q[rd_ptr_q];

    // The starved head overrides the WB stage; otherwise WB has priority.
    if (starve)           gnt = GNT_LT;
    else if (ws_we)       gnt = GNT_WS;
    else if (fifo_nempty) gnt = GNT_LT;
    else                  gnt = GNT_IDLE;

    ws_ready = !starve;
    lt_ready = !fifo_full;
    push     = lt_valid && !fifo_full;
    pop      = (gnt == GNT_LT);
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    unique case (gnt)
      GNT_WS: begin
        rf_waddr = ws_waddr;
        rf_wdata = ws_wdata;
        rf_we    = (ws_waddr != 5'd0);
      end
      GNT_LT: begin
        rf_waddr = head_addr;
        rf_wdata = head_data;
        rf_we    = (head_addr != 5'd0);
      end
      default: ;
    endcase
  end

  always_comb begin
    occ_d        = occ_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    starve_cnt_d = starve_cnt_q;
    addr_d       = addr_q;
    data_d       = data_q;

    if (push) begin
      addr_d[wr_ptr_q] = lt_waddr;
      data_d[wr_ptr_q] = lt_wdata;
      wr_ptr_d         = !wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = !rd_ptr_q;
    end

    if (push && !pop)      occ_d = occ_q + 2'd1;
    else if (pop && !push) occ_d = occ_q - 2'd1;

    // The counter measures how long the current head has been waiting.
    if (pop || !fifo_nempty)           starve_cnt_d = 4'd0;
    else if (starve_cnt_q < STARVE_LIM) starve_cnt_d = starve_cnt_q + 4'd1;
  end

  always_comb begin
    ent_vld   = 2'b00;
    pend_mask = 32'd0;
    if (occ_q == 2'd2)      ent_vld = 2'b11;
    else if (occ_q == 2'd1) ent_vld[rd_ptr_q] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (ent_vld[i]) pend_mask[addr_q[i]] = 1'b1;
    end
    pend_mask[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      occ_q        <= 2'd0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      starve_cnt_q <= 4'd0;
      for (int i = 0; i < 2; i++) begin
        addr_q[i] <= 5'd0;
        data_q[i] <= 32'd0;
      end
    end else begin
      occ_q        <= occ_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      starve_cnt_q <= starve_cnt_d;
      for (int i = 0; i < 2; i++) begin
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

endmodule
